// File: rtl/lvds_sd_adc.sv
`default_nettype none
// ============================================================================
// Module   : lvds_sd_adc
// Purpose  : Multi-channel sigma-delta ADC front end for iCE40 LVDS
//            comparator inputs. Each channel synchronises its comparator bit,
//            returns it as the 1-bit DAC feedback and counts ones over a
//            2^DECIM_LOG2-cycle window to form an unsigned sample. All
//            channels share one valid/ready output with a sticky overrun flag.
// Ports    : clk          - system clock
//            rst_n        - asynchronous active-low reset
//            en           - conversion enable (low discards the partial window)
//            comp_in      - raw comparator bits, one per channel (async)
//            fb_out       - registered feedback bits to the RC DAC pins
//            sample_data  - channel n at [n*SW +: SW], SW = DECIM_LOG2+1
//            sample_valid - sample_data holds an unconsumed sample
//            sample_ready - consumer accepts when valid and ready are high
//            overrun      - sticky: an unconsumed sample was overwritten
//            clr_ovr      - synchronous clear of overrun
//            heartbeat    - LED blink
// Options  : HEARTBEAT_EN - when defined, heartbeat is bit BLINK_LOG2 of a
//            free-running counter; otherwise heartbeat is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module lvds_sd_adc #(
  parameter int CHANNELS    = 1,
  parameter int DECIM_LOG2  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BLINK_LOG2  = 25
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [CHANNELS-1:0]                  comp_in,
  output logic [CHANNELS-1:0]                  fb_out,
  output logic [CHANNELS*(DECIM_LOG2+1)-1:0]   sample_data,
  output logic                                 sample_valid,
  input  logic                                 sample_ready,
  output logic                                 overrun,
  input  logic                                 clr_ovr,
  output logic                                 heartbeat
);

  // Sample width: a full window of ones (2^DECIM_LOG2) needs one extra bit.
  localparam int                    c_sw       = DECIM_LOG2 + 1;
  localparam logic [DECIM_LOG2-1:0] c_win_last = '1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || BLINK_LOG2 < 1) begin : g_param_check
    $error("lvds_sd_adc: SYNC_STAGES must be 2..4 and BLINK_LOG2 >= 1");
  end

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0]          r_sync [CHANNELS];
  logic [c_sw-1:0]                 r_acc  [CHANNELS];
  logic [c_sw-1:0]                 w_sum  [CHANNELS];
  logic [CHANNELS-1:0]             w_s;
  logic [CHANNELS-1:0]             r_fb;
  logic [CHANNELS*c_sw-1:0]        r_data;
  logic [DECIM_LOG2-1:0]           r_win;
  logic                            w_tc;
  logic                            r_ovr;
  logic                            w_ovr_set;
  state_t                          r_state;
  state_t                          w_state_nxt;

  // Last synchroniser stage and the running sum including this cycle's bit.
  always_comb begin
    w_s = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_s[n]   = r_sync[n][SYNC_STAGES-1];
      w_sum[n] = r_acc[n] + {{DECIM_LOG2{1'b0}}, w_s[n]};
    end
  end

  assign w_tc = en && (r_win == c_win_last);

  // Shared window counter; held at zero while disabled so en rising always
  // starts a complete window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (!en) begin
      r_win <= '0;
    end else begin
      r_win <= r_win + 1'b1;
    end
  end

  // Per-channel synchroniser, feedback and accumulator. The feedback path
  // runs regardless of en so the external loop stays settled while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_sync[n] <= '0;
        r_acc[n]  <= '0;
      end
      r_fb   <= '0;
      r_data <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_sync[n] <= {r_sync[n][SYNC_STAGES-2:0], comp_in[n]};
        r_fb[n]   <= w_s[n];
        if (!en) begin
          r_acc[n] <= '0;
        end else if (w_tc) begin
          // The bit of the terminal cycle belongs to the closing window.
          r_acc[n]                 <= '0;
          r_data[n*c_sw +: c_sw]   <= w_sum[n];
        end else begin
          r_acc[n] <= w_sum[n];
        end
      end
    end
  end

  // Output handshake FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ovr_set   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_tc) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_tc) begin
          // New data lands this edge; lost only if the old one was not taken.
          w_ovr_set = !sample_ready;
        end else if (sample_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Overrun is sticky; a simultaneous new event beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
    end else if (w_ovr_set) begin
      r_ovr <= 1'b1;
    end else if (clr_ovr) begin
      r_ovr <= 1'b0;
    end
  end

  assign fb_out       = r_fb;
  assign sample_data  = r_data;
  assign sample_valid = (r_state == ST_FULL);
  assign overrun      = r_ovr;

`ifdef HEARTBEAT_EN
  logic [BLINK_LOG2:0] r_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end

  assign heartbeat = r_blink[BLINK_LOG2];
`else
  assign heartbeat = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lvds_sd_adc.sv
`default_nettype none
// ============================================================================
// Module   : tb_lvds_sd_adc
// Purpose  : Self-checking bench for lvds_sd_adc (2 channels, 16-cycle
//            window, 2 synchroniser stages). Expected samples are queued when
//            the stimulus is set up and popped whenever the DUT hands a
//            sample over (valid and ready high).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_sd_adc;

  localparam int CH  = 2;
  localparam int DL2 = 4;
  localparam int SW  = DL2 + 1;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [CH-1:0]     comp_in;
  logic [CH-1:0]     fb_out;
  logic [CH*SW-1:0]  sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              overrun;
  logic              clr_ovr;
  logic              heartbeat;

  lvds_sd_adc #(
    .CHANNELS    (CH),
    .DECIM_LOG2  (DL2),
    .SYNC_STAGES (2),
    .BLINK_LOG2  (3)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .comp_in      (comp_in),
    .fb_out       (fb_out),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clr_ovr      (clr_ovr),
    .heartbeat    (heartbeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          last_acc = -1;
  bit          mon_en = 1'b0;
  bit          per_chk = 1'b0;
  bit          tog = 1'b0;
  logic [3:0]  hist = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && mon_en && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", sample_data, 32'hFFFF_FFFF);
      end else begin
        chk("sample", sample_data, exp_q.pop_front());
        chk("overrun_clear", overrun, 0);
      end
      if (per_chk && last_acc >= 0) chk("valid_period", cyc - last_acc, 16);
      last_acc = cyc;
    end
  end

  // Advance n clocks; inputs change 2 ns after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (tog) comp_in[0] = ~comp_in[0];
      hist = {hist[2:0], comp_in[0]};
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      step(1);
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] pack(input int c1, input int c0);
    return (c1 << SW) | c0;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; comp_in = '0; sample_ready = 1'b0; clr_ovr = 1'b0;
    step(2);
    #1;
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_fb", fb_out, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_hb", heartbeat, 0);

    // Constant 1 on ch0, 0 on ch1: first window loses the sync latency.
    comp_in = 2'b01; en = 1'b1; sample_ready = 1'b1; rst_n = 1'b1;
    exp_q.push_back(pack(0, 14));
    exp_q.push_back(pack(0, 16));
    exp_q.push_back(pack(0, 16));
    per_chk = 1'b1; mon_en = 1'b1;
    wait_drain(70);
    per_chk = 1'b0;
    #1;
    chk("fb_const", fb_out, 2'b01);
    chk("ovr_const", overrun, 0);

    // Alternating ch0, constant 1 on ch1; fb_out lags comp_in by 3 clocks.
    en = 1'b0; comp_in[1] = 1'b1; tog = 1'b1;
    step(3);
    en = 1'b1;
    exp_q.push_back(pack(16, 8));
    exp_q.push_back(pack(16, 8));
    for (int i = 0; i < 4; i++) begin
      step(1);
      #1;
      chk("fb_delay", fb_out[0], hist[3]);
    end
    wait_drain(50);
    tog = 1'b0;

    // Overrun: nobody takes two windows.
    mon_en = 1'b0; en = 1'b0; comp_in = 2'b01; sample_ready = 1'b0;
    step(3);
    en = 1'b1;
    step(16);
    #1;
    chk("ovr_w1_valid", sample_valid, 1);
    chk("ovr_w1_flag", overrun, 0);
    chk("ovr_w1_data", sample_data, pack(0, 16));
    step(16);
    #1;
    chk("ovr_w2_flag", overrun, 1);
    chk("ovr_w2_valid", sample_valid, 1);
    chk("ovr_w2_data", sample_data, pack(0, 16));
    comp_in = 2'b11;   // ch1 counted from the 3rd edge of window 3 -> 14
    step(2);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    #1;
    chk("clr_ovr_flag", overrun, 0);
    chk("clr_ovr_valid", sample_valid, 1);

    // Accept exactly on the terminal-count cycle while FULL.
    step(12);
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    #1;
    chk("tc_acc_valid", sample_valid, 1);
    chk("tc_acc_ovr", overrun, 0);
    chk("tc_acc_data", sample_data, pack(14, 16));

    // Drain, then drop en for 3 cycles mid-window: no sample may appear.
    exp_q.push_back(pack(14, 16));
    sample_ready = 1'b1; mon_en = 1'b1;
    step(2);
    #1;
    chk("drained_valid", sample_valid, 0);
    step(2);
    en = 1'b0;
    step(3);
    #1;
    chk("en_low_valid", sample_valid, 0);
    en = 1'b1;
    exp_q.push_back(pack(16, 16));
    step(15);
    #1;
    chk("fresh_w_early", sample_valid, 0);
    step(1);
    #1;
    chk("fresh_w_valid", sample_valid, 1);
    chk("fresh_w_data", sample_data, pack(16, 16));

    // Reset at window count 7 acts immediately, without a clock edge.
    step(7);
    rst_n = 1'b0;
    #1;
    chk("arst_fb", fb_out, 0);
    chk("arst_data", sample_data, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_ovr", overrun, 0);
    step(1);
    rst_n = 1'b1;
    exp_q.push_back(pack(14, 14));
    exp_q.push_back(pack(16, 16));
    step(15);
    #1;
    chk("post_rst_early", sample_valid, 0);
    step(1);
    #1;
    chk("post_rst_valid", sample_valid, 1);
    wait_drain(40);
    chk("hb_default", heartbeat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
